// File: rtl/sound_player.sv
// sound_player
//   Square-wave tone generator for the board buzzer. Plays ping, pong and a
//   two-note "go" jingle when the requested code from the motion block changes.
//   The code and mute inputs come from a slow animation clock, so both are
//   brought into the clk domain through two flops each before use.
//
// Ports
//   clk        system clock
//   clr        asynchronous active-low reset
//   code_sound requested sound: 00 stop, 01 pong, 10 ping, 11 go (async)
//   mute       silence request, active high (async)
//   speaker    square-wave audio output
//   busy       high while a note is sounding
//   cur_sound  code currently playing, 00 when idle
//
// state  | meaning
// IDLE   | silent, waiting for a code change
// NOTE_A | first (or only) note of the current sound
// NOTE_B | second note of the go jingle
module sound_player #(
  parameter int HALF_PING = 6000,
  parameter int HALF_PONG = 12000,
  parameter int HALF_GO_A = 8000,
  parameter int HALF_GO_B = 4000,
  parameter int DUR       = 1200000,
  parameter int DUR_W     = 24,
  parameter int DIV_W     = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] code_sound,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] cur_sound
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NOTE_A = 2'd1,
    NOTE_B = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] H_PING   = DIV_W'(HALF_PING);
  localparam logic [DIV_W-1:0] H_PONG   = DIV_W'(HALF_PONG);
  localparam logic [DIV_W-1:0] H_GO_A   = DIV_W'(HALF_GO_A);
  localparam logic [DIV_W-1:0] H_GO_B   = DIV_W'(HALF_GO_B);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR - 1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  logic [1:0]       s1, s2, code_prev;
  logic             m1, mute_s;
  state_t           state, state_n;
  logic [DIV_W-1:0] half, half_n, half_sel;
  logic [DUR_W-1:0] dur_cnt, dur_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic             tone, tone_n;
  logic [1:0]       cur_n;
  logic             new_req;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1        <= 2'b00;
      s2        <= 2'b00;
      code_prev <= 2'b00;
      m1        <= 1'b0;
      mute_s    <= 1'b0;
    end else begin
      s1        <= code_sound;
      s2        <= s1;
      code_prev <= s2;
      m1        <= mute;
      mute_s    <= m1;
    end
  end

  // Only an edge on the synchronised code counts; dropping to 00 never stops a note.
  assign new_req = (s2 != code_prev) && (s2 != 2'b00);

  always_comb begin
    case (s2)
      2'b01:   half_sel = H_PONG;
      2'b10:   half_sel = H_PING;
      default: half_sel = H_GO_A;
    endcase
  end

  always_comb begin
    state_n = state;
    half_n  = half;
    dur_n   = dur_cnt;
    div_n   = div_cnt;
    tone_n  = tone;
    cur_n   = cur_sound;
    if (new_req) begin
      // Entry from IDLE and preemption share this path, and win over note-end.
      state_n = NOTE_A;
      half_n  = half_sel;
      cur_n   = s2;
      dur_n   = '0;
      div_n   = '0;
      tone_n  = 1'b0;
    end else begin
      case (state)
        NOTE_A, NOTE_B: begin
          if (dur_cnt == DUR_LAST) begin
            dur_n  = '0;
            div_n  = '0;
            tone_n = 1'b0;
            if (state == NOTE_A && cur_sound == 2'b11) begin
              state_n = NOTE_B;
              half_n  = H_GO_B;
            end else begin
              state_n = IDLE;
              cur_n   = 2'b00;
            end
          end else begin
            dur_n = dur_cnt + DUR_ONE;
            if (div_cnt == half - DIV_ONE) begin
              div_n  = '0;
              tone_n = ~tone;
            end else begin
              div_n = div_cnt + DIV_ONE;
            end
          end
        end
        default: begin
          state_n = IDLE;
          cur_n   = 2'b00;
          dur_n   = '0;
          div_n   = '0;
          tone_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      half      <= '0;
      dur_cnt   <= '0;
      div_cnt   <= '0;
      tone      <= 1'b0;
      cur_sound <= 2'b00;
      busy      <= 1'b0;
      speaker   <= 1'b0;
    end else begin
      state     <= state_n;
      half      <= half_n;
      dur_cnt   <= dur_n;
      div_cnt   <= div_n;
      tone      <= tone_n;
      cur_sound <= cur_n;
      busy      <= (state_n != IDLE);
      // Mute gates only the pin; tone keeps running so unmuting stays in phase.
      speaker   <= tone_n & ~mute_s;
    end
  end

endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player
//   Directed bench for sound_player with shortened tone and note lengths.
module tb_sound_player;

  localparam int DUR = 48;

  logic       clk;
  logic       clr;
  logic [1:0] code_sound;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic [1:0] cur_sound;

  int n_vec = 0;
  int n_err = 0;

  sound_player #(
    .HALF_PING(4),
    .HALF_PONG(8),
    .HALF_GO_A(6),
    .HALF_GO_B(3),
    .DUR      (DUR),
    .DUR_W    (24),
    .DIV_W    (16)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .code_sound(code_sound),
    .mute      (mute),
    .speaker   (speaker),
    .busy      (busy),
    .cur_sound (cur_sound)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {1'b0, busy}, 2'b00);
    chk({tag, "_spk"},  {1'b0, speaker}, 2'b00);
    chk({tag, "_cur"},  cur_sound, 2'b00);
  endtask

  // Drive a new code and walk to the note-entry edge (third edge after the change).
  task automatic request(input logic [1:0] code, input logic busy_before);
    code_sound = code;
    step(2);
    chk("pre_entry_busy", {1'b0, busy}, {1'b0, busy_before});
    step(1);
  endtask

  // Check note samples k = kfrom..kto, where k=0 is just after the entry edge.
  // Mute is raised after the sample at k==m and dropped after k==u; the pin
  // is silent from m+3 through u+2 because of the two sync flops plus the
  // registered output.
  task automatic run_note(input int half, input logic [1:0] code,
                          input int kfrom, input int kto, input int m, input int u);
    logic exp_spk;
    for (int k = kfrom; k <= kto; k++) begin
      if (k != 0) step(1);
      exp_spk = ((k / half) % 2) == 1;
      if (m >= 0 && k >= m + 3 && k <= u + 2) exp_spk = 1'b0;
      chk("note_spk",  {1'b0, speaker}, {1'b0, exp_spk});
      chk("note_busy", {1'b0, busy}, 2'b01);
      chk("note_cur",  cur_sound, code);
      if (k == m) mute = 1'b1;
      if (k == u) mute = 1'b0;
    end
  endtask

  initial begin
    clr        = 1'b0;
    code_sound = 2'b10;
    mute       = 1'b0;

    // Reset with ping requested on the input
    step(4);
    chk_idle("reset");
    clr = 1'b1;
    request(2'b10, 1'b0);
    run_note(4, 2'b10, 0, DUR - 1, -1, -1);
    step(1);
    chk_idle("ping_end");

    // Go jingle: two notes back to back, busy never drops
    code_sound = 2'b00;
    step(4);
    request(2'b11, 1'b0);
    run_note(6, 2'b11, 0, DUR - 1, -1, -1);
    step(1);
    run_note(3, 2'b11, 0, DUR - 1, -1, -1);
    step(1);
    chk_idle("go_end");

    // Preempt ping with pong twenty cycles in
    request(2'b10, 1'b0);
    run_note(4, 2'b10, 0, 20, -1, -1);
    code_sound = 2'b01;
    run_note(4, 2'b10, 21, 22, -1, -1);
    step(1);
    run_note(8, 2'b01, 0, DUR - 1, -1, -1);
    step(1);
    chk_idle("pong_end");

    // Holding the same code does not retrigger
    step(30);
    chk_idle("no_retrig");

    // Mute during pong, unmute mid-note
    code_sound = 2'b00;
    step(4);
    request(2'b01, 1'b0);
    run_note(8, 2'b01, 0, DUR - 1, 9, 29);
    step(1);
    chk_idle("mute_end");

    // Dropping to 00 mid-note lets the note finish
    request(2'b10, 1'b0);
    run_note(4, 2'b10, 0, 9, -1, -1);
    code_sound = 2'b00;
    run_note(4, 2'b10, 10, DUR - 1, -1, -1);
    step(1);
    chk_idle("stop_end");
    step(10);
    chk_idle("stop_quiet");

    // Reset in the middle of a note
    request(2'b11, 1'b0);
    run_note(6, 2'b11, 0, 10, -1, -1);
    clr        = 1'b0;
    code_sound = 2'b00;
    #1;
    chk_idle("mid_reset");
    step(2);
    clr = 1'b1;
    step(10);
    chk_idle("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
